reorder_buffer: RTL and testbench



---
 rtl/reorder_buffer_if.sv | 52 +++++
 rtl/reorder_buffer.sv | 148 ++++++++++++++
 tb/tb_reorder_buffer.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_if.sv
// Decoder / reservation-station / CDB / regfile-facing bus of the reorder buffer.
// The master side drives requests; the slave side is the reorder buffer.
interface reorder_buffer_if #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned VAL_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned REG_WIDTH  = 5
);
  logic                  issue_valid;
  logic [1:0]            issue_kind;
  logic [REG_WIDTH-1:0]  issue_rd;
  logic [ADDR_WIDTH-1:0] issue_pc;
  logic [ID_WIDTH-1:0]   newTag;
  logic                  isFull;

  logic [ID_WIDTH-1:0]   label1;
  logic [ID_WIDTH-1:0]   label2;
  logic                  ready1;
  logic                  ready2;
  logic [VAL_WIDTH-1:0]  res1;
  logic [VAL_WIDTH-1:0]  res2;

  logic                  cdbReady;
  logic [ID_WIDTH-1:0]   cdb2lab;
  logic [VAL_WIDTH-1:0]  cdb2val;
  logic                  cdb_mispred;
  logic [ADDR_WIDTH-1:0] cdb_target;

  logic                  commit_valid;
  logic [REG_WIDTH-1:0]  commit_rd;
  logic [VAL_WIDTH-1:0]  commit_val;
  logic [ID_WIDTH-1:0]   commit_tag;
  logic                  store_commit;
  logic                  flush_out;
  logic [ADDR_WIDTH-1:0] redirect_pc;

  modport master (
    output issue_valid, issue_kind, issue_rd, issue_pc, label1, label2,
           cdbReady, cdb2lab, cdb2val, cdb_mispred, cdb_target,
    input  newTag, isFull, ready1, ready2, res1, res2,
           commit_valid, commit_rd, commit_val, commit_tag, store_commit,
           flush_out, redirect_pc
  );

  modport slave (
    input  issue_valid, issue_kind, issue_rd, issue_pc, label1, label2,
           cdbReady, cdb2lab, cdb2val, cdb_mispred, cdb_target,
    output newTag, isFull, ready1, ready2, res1, res2,
           commit_valid, commit_rd, commit_val, commit_tag, store_commit,
           flush_out, redirect_pc
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: tag allocation, operand lookup with CDB bypass,
// result capture and in-order retirement with mispredicted-branch flush.
module reorder_buffer #(
  parameter int unsigned ROB_SIZE   = 8,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned VAL_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned REG_WIDTH  = 5
) (
  input logic             clk,
  input logic             rst_in,
  input logic             rdy_in,
  reorder_buffer_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(ROB_SIZE);
  localparam int unsigned CNT_W = IDX_W + 1;

  localparam logic [1:0] KIND_REG    = 2'd0;
  localparam logic [1:0] KIND_BRANCH = 2'd1;
  localparam logic [1:0] KIND_STORE  = 2'd2;

  typedef struct packed {
    logic                  done;
    logic                  mispred;
    logic [1:0]            kind;
    logic [REG_WIDTH-1:0]  rd;
    logic [VAL_WIDTH-1:0]  val;
    logic [ADDR_WIDTH-1:0] target;
  } entry_t;

  // Only the busy vector needs reset; payload is qualified by busy everywhere.
  entry_t              rob [ROB_SIZE];
  logic [ROB_SIZE-1:0] busy;
  logic [IDX_W-1:0]    head;
  logic [IDX_W-1:0]    tail;
  logic [CNT_W-1:0]    count;

  logic             issue_ok;
  logic             retire;
  logic             flush_now;
  logic             wb_hit;
  logic [IDX_W-1:0] wb_idx;
  logic [IDX_W-1:0] idx1;
  logic [IDX_W-1:0] idx2;
  entry_t           head_e;
  logic             pc_unused;

  function automatic logic tag_ok(input logic [ID_WIDTH-1:0] tag);
    return (tag != '0) && (tag <= ID_WIDTH'(ROB_SIZE));
  endfunction

  function automatic logic [IDX_W-1:0] tag_idx(input logic [ID_WIDTH-1:0] tag);
    return IDX_W'(tag - ID_WIDTH'(1));
  endfunction

  assign pc_unused = ^bus.issue_pc;

  assign bus.isFull = (count == CNT_W'(ROB_SIZE));
  assign bus.newTag = ID_WIDTH'(tail) + ID_WIDTH'(1);

  assign head_e    = rob[head];
  assign retire    = busy[head] && head_e.done;
  assign flush_now = retire && head_e.mispred && (head_e.kind == KIND_BRANCH);
  assign issue_ok  = bus.issue_valid && !bus.isFull && !bus.flush_out;
  assign wb_idx    = tag_idx(bus.cdb2lab);
  assign wb_hit    = bus.cdbReady && tag_ok(bus.cdb2lab) && busy[wb_idx];
  assign idx1      = tag_idx(bus.label1);
  assign idx2      = tag_idx(bus.label2);

  // Operand lookup: stored result first, then same-cycle CDB bypass.
  always_comb begin
    bus.ready1 = 1'b0;
    bus.res1   = '0;
    bus.ready2 = 1'b0;
    bus.res2   = '0;
    if (tag_ok(bus.label1) && busy[idx1]) begin
      if (rob[idx1].done) begin
        bus.ready1 = 1'b1;
        bus.res1   = rob[idx1].val;
      end else if (bus.cdbReady && (bus.cdb2lab == bus.label1)) begin
        bus.ready1 = 1'b1;
        bus.res1   = bus.cdb2val;
      end
    end
    if (tag_ok(bus.label2) && busy[idx2]) begin
      if (rob[idx2].done) begin
        bus.ready2 = 1'b1;
        bus.res2   = rob[idx2].val;
      end else if (bus.cdbReady && (bus.cdb2lab == bus.label2)) begin
        bus.ready2 = 1'b1;
        bus.res2   = bus.cdb2val;
      end
    end
  end

  // Pointers, entries and registered retirement outputs.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      busy             <= '0;
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      bus.commit_valid <= 1'b0;
      bus.store_commit <= 1'b0;
      bus.flush_out    <= 1'b0;
      bus.commit_rd    <= '0;
      bus.commit_val   <= '0;
      bus.commit_tag   <= '0;
      bus.redirect_pc  <= '0;
    end else if (rdy_in) begin
      bus.commit_valid <= retire;
      bus.store_commit <= retire && (head_e.kind == KIND_STORE);
      bus.flush_out    <= flush_now;
      if (retire) begin
        bus.commit_rd  <= head_e.rd;
        bus.commit_val <= head_e.val;
        bus.commit_tag <= ID_WIDTH'(head) + ID_WIDTH'(1);
      end
      if (flush_now) begin
        bus.redirect_pc <= head_e.target;
        busy            <= '0;
        head            <= '0;
        tail            <= '0;
        count           <= '0;
      end else begin
        if (wb_hit) begin
          rob[wb_idx].done    <= 1'b1;
          rob[wb_idx].val     <= bus.cdb2val;
          rob[wb_idx].mispred <= bus.cdb_mispred;
          rob[wb_idx].target  <= bus.cdb_target;
        end
        // A full buffer never issues, so tail cannot alias head or the CDB target.
        if (issue_ok) begin
          busy[tail] <= 1'b1;
          rob[tail]  <= '{done: 1'b0, mispred: 1'b0, kind: bus.issue_kind,
                          rd: (bus.issue_kind == KIND_REG) ? bus.issue_rd : '0,
                          val: '0, target: '0};
        end
        if (retire) begin
          busy[head] <= 1'b0;
        end
        head  <= head + IDX_W'(retire);
        tail  <= tail + IDX_W'(issue_ok);
        count <= count + CNT_W'(issue_ok) - CNT_W'(retire);
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: issues push expected retirements, commits pop
// and compare; lookups, full/wrap, flush, hold and reset are checked around them.
module tb_reorder_buffer;
  localparam int ROB = 8;
  localparam logic [1:0] K_REG = 2'd0;
  localparam logic [1:0] K_BR  = 2'd1;
  localparam logic [1:0] K_ST  = 2'd2;

  typedef struct packed {
    logic [3:0] tag;
    logic [4:0] rd;
    logic [1:0] kind;
  } exp_t;

  logic clk;
  logic rst_in;
  logic rdy_in;

  reorder_buffer_if bus ();

  reorder_buffer dut (
    .clk    (clk),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus.slave)
  );

  int   checks      = 0;
  int   errors      = 0;
  int   n_commits   = 0;
  int   model_tail  = 0;
  int   model_count = 0;
  logic flush_next  = 1'b0;
  exp_t exp_q [$];
  logic [31:0] exp_val [1:ROB];
  logic        exp_mis [1:ROB];
  logic [31:0] exp_tgt [1:ROB];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0;
    bus.issue_kind  = 2'd0;
    bus.issue_rd    = 5'd0;
    bus.issue_pc    = 32'd0;
    bus.label1      = 4'd0;
    bus.label2      = 4'd0;
    bus.cdbReady    = 1'b0;
    bus.cdb2lab     = 4'd0;
    bus.cdb2val     = 32'd0;
    bus.cdb_mispred = 1'b0;
    bus.cdb_target  = 32'd0;
  endtask

  task automatic drive_issue(input logic [1:0] kind, input logic [4:0] rd, input logic [31:0] pc);
    bus.issue_valid = 1'b1;
    bus.issue_kind  = kind;
    bus.issue_rd    = rd;
    bus.issue_pc    = pc;
  endtask

  task automatic drive_cdb(input logic [3:0] tag, input logic [31:0] val,
                           input logic mis, input logic [31:0] tgt);
    bus.cdbReady    = 1'b1;
    bus.cdb2lab     = tag;
    bus.cdb2val     = val;
    bus.cdb_mispred = mis;
    bus.cdb_target  = tgt;
  endtask

  // One clock edge: sample the stimulus, then score what the DUT did at the edge.
  task automatic step();
    logic        rst_s, rdy_s, acc, cdb_s, mis_s, flush_now;
    logic [3:0]  tag_s;
    logic [31:0] val_s, tgt_s;
    logic [1:0]  kind_s;
    logic [4:0]  rd_s;
    exp_t        e;
    rst_s  = rst_in;
    rdy_s  = rdy_in;
    acc    = bus.issue_valid && (model_count < ROB) && !flush_next;
    kind_s = bus.issue_kind;
    rd_s   = bus.issue_rd;
    cdb_s  = bus.cdbReady;
    tag_s  = bus.cdb2lab;
    val_s  = bus.cdb2val;
    mis_s  = bus.cdb_mispred;
    tgt_s  = bus.cdb_target;
    @(posedge clk);
    #1;
    if (rst_s) begin
      exp_q.delete();
      model_tail  = 0;
      model_count = 0;
      flush_next  = 1'b0;
      check("rst_commit_valid", 64'(bus.commit_valid), 64'(0));
      check("rst_flush_out", 64'(bus.flush_out), 64'(0));
      return;
    end
    if (!rdy_s) return;
    flush_now = 1'b0;
    if (bus.commit_valid) begin
      n_commits++;
      if (exp_q.size() == 0) begin
        check("spurious_commit_tag", 64'(bus.commit_tag), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("commit_tag", 64'(bus.commit_tag), 64'(e.tag));
        check("commit_rd", 64'(bus.commit_rd), 64'(e.rd));
        check("commit_val", 64'(bus.commit_val), 64'(exp_val[e.tag]));
        check("store_commit", 64'(bus.store_commit), 64'(e.kind == K_ST));
        flush_now = (e.kind == K_BR) && exp_mis[e.tag];
        if (flush_now) check("redirect_pc", 64'(bus.redirect_pc), 64'(exp_tgt[e.tag]));
      end
      model_count--;
    end
    check("flush_out", 64'(bus.flush_out), 64'(flush_now));
    if (cdb_s && !flush_now && (tag_s >= 4'd1) && (tag_s <= 4'(ROB))) begin
      exp_val[tag_s] = val_s;
      exp_mis[tag_s] = mis_s;
      exp_tgt[tag_s] = tgt_s;
    end
    if (flush_now) begin
      exp_q.delete();
      model_tail  = 0;
      model_count = 0;
    end else if (acc) begin
      exp_q.push_back('{tag: 4'(model_tail + 1), rd: (kind_s == K_REG) ? rd_s : 5'd0, kind: kind_s});
      model_tail = (model_tail + 1) % ROB;
      model_count++;
    end
    flush_next = flush_now;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    idle();
    step();
    rst_in = 1'b0;
  endtask

  task automatic wait_commits(input int target, input int budget);
    int n;
    n = 0;
    while ((n_commits < target) && (n < budget)) begin
      step();
      n++;
    end
    check("commit_timeout", 64'(n_commits >= target), 64'(1));
  endtask

  task automatic issue_checked(input logic [1:0] kind, input logic [4:0] rd);
    drive_issue(kind, rd, 32'h1000 + 32'(model_tail) * 32'd4);
    #1;
    check("newTag", 64'(bus.newTag), 64'(model_tail + 1));
    step();
    idle();
  endtask

  initial begin
    int base;
    for (int i = 1; i <= ROB; i++) begin
      exp_val[i] = 32'd0;
      exp_mis[i] = 1'b0;
      exp_tgt[i] = 32'd0;
    end
    rst_in = 1'b1;
    rdy_in = 1'b1;
    idle();
    step();
    step();
    rst_in = 1'b0;

    // Reset state
    check("rst_newTag", 64'(bus.newTag), 64'(1));
    check("rst_isFull", 64'(bus.isFull), 64'(0));
    check("rst_store_commit", 64'(bus.store_commit), 64'(0));
    check("rst_commit_rd", 64'(bus.commit_rd), 64'(0));
    check("rst_commit_val", 64'(bus.commit_val), 64'(0));
    check("rst_commit_tag", 64'(bus.commit_tag), 64'(0));
    check("rst_redirect_pc", 64'(bus.redirect_pc), 64'(0));

    // Single REG instruction, result one edge, retire the next
    drive_issue(K_REG, 5'd5, 32'h100);
    #1;
    check("t1_newTag", 64'(bus.newTag), 64'(1));
    step();
    idle();
    drive_cdb(4'd1, 32'h2A, 1'b0, 32'd0);
    step();
    idle();
    check("t1_not_yet", 64'(bus.commit_valid), 64'(0));
    step();
    check("t1_commit_valid", 64'(bus.commit_valid), 64'(1));

    // Fill, ignored ninth issue, retire frees a slot, tag wraps
    do_reset();
    for (int i = 0; i < ROB; i++) issue_checked(K_REG, 5'(i + 1));
    check("full_isFull", 64'(bus.isFull), 64'(1));
    drive_issue(K_REG, 5'd30, 32'h2000);
    #1;
    check("full_newTag", 64'(bus.newTag), 64'(1));
    step();
    idle();
    drive_cdb(4'd1, 32'hA1, 1'b0, 32'd0);
    step();
    idle();
    check("full_still", 64'(bus.isFull), 64'(1));
    step();
    check("full_drop", 64'(bus.isFull), 64'(0));
    issue_checked(K_REG, 5'd20);
    check("full_again", 64'(bus.isFull), 64'(1));
    base = n_commits;
    for (int t = 2; t <= ROB + 1; t++) begin
      drive_cdb(4'(((t - 1) % ROB) + 1), 32'hB0 + 32'(t), 1'b0, 32'd0);
      step();
    end
    idle();
    wait_commits(base + ROB, 12);
    check("drain_queue_empty", 64'(exp_q.size()), 64'(0));

    // Lookup with same-cycle CDB bypass
    do_reset();
    issue_checked(K_REG, 5'd1);
    issue_checked(K_REG, 5'd2);
    issue_checked(K_REG, 5'd3);
    drive_cdb(4'd3, 32'd7, 1'b0, 32'd0);
    bus.label1 = 4'd3;
    bus.label2 = 4'd0;
    #1;
    check("byp_ready1", 64'(bus.ready1), 64'(1));
    check("byp_res1", 64'(bus.res1), 64'(7));
    check("byp_ready2_zero", 64'(bus.ready2), 64'(0));
    check("byp_res2_zero", 64'(bus.res2), 64'(0));
    bus.label2 = 4'd2;
    #1;
    check("byp_ready2_pending", 64'(bus.ready2), 64'(0));
    step();
    idle();
    bus.label1 = 4'd3;
    #1;
    check("stored_ready1", 64'(bus.ready1), 64'(1));
    check("stored_res1", 64'(bus.res1), 64'(7));
    base = n_commits;
    drive_cdb(4'd1, 32'h11, 1'b0, 32'd0);
    step();
    drive_cdb(4'd2, 32'h22, 1'b0, 32'd0);
    step();
    idle();
    wait_commits(base + 3, 10);

    // Mispredicted branch: in-order retire, flush, younger work discarded
    do_reset();
    issue_checked(K_REG, 5'd1);
    issue_checked(K_BR, 5'd0);
    issue_checked(K_REG, 5'd3);
    drive_cdb(4'd3, 32'h33, 1'b0, 32'd0);
    step();
    drive_cdb(4'd2, 32'd0, 1'b1, 32'h200);
    step();
    drive_cdb(4'd1, 32'h11, 1'b0, 32'd0);
    step();
    idle();
    step();
    check("mp_tag1", 64'(bus.commit_tag), 64'(1));
    drive_issue(K_REG, 5'd9, 32'h300);
    step();
    idle();
    check("mp_flush", 64'(bus.flush_out), 64'(1));
    check("mp_redirect", 64'(bus.redirect_pc), 64'(32'h200));
    check("mp_commit_tag", 64'(bus.commit_tag), 64'(2));
    check("mp_newTag", 64'(bus.newTag), 64'(1));
    drive_issue(K_REG, 5'd10, 32'h200);
    step();
    idle();
    check("mp_flush_gone", 64'(bus.flush_out), 64'(0));
    check("mp_newTag_blocked", 64'(bus.newTag), 64'(1));
    issue_checked(K_REG, 5'd11);
    step();
    step();
    step();
    base = n_commits;
    drive_cdb(4'd1, 32'h77, 1'b0, 32'd0);
    step();
    idle();
    wait_commits(base + 1, 5);

    // STORE retire, and commit pulses held while stalled
    do_reset();
    issue_checked(K_ST, 5'd7);
    drive_cdb(4'd1, 32'hDEAD, 1'b0, 32'd0);
    step();
    idle();
    step();
    check("st_store_commit", 64'(bus.store_commit), 64'(1));
    check("st_commit_rd", 64'(bus.commit_rd), 64'(0));
    rdy_in = 1'b0;
    step();
    check("hold_commit_valid", 64'(bus.commit_valid), 64'(1));
    check("hold_store_commit", 64'(bus.store_commit), 64'(1));
    rdy_in = 1'b1;
    step();
    check("st_pulse_end", 64'(bus.store_commit), 64'(0));

    // Stall with issue and CDB pending: nothing moves
    do_reset();
    issue_checked(K_REG, 5'd4);
    rdy_in = 1'b0;
    drive_issue(K_REG, 5'd6, 32'h400);
    drive_cdb(4'd1, 32'h55, 1'b0, 32'd0);
    step();
    step();
    check("stall_newTag", 64'(bus.newTag), 64'(2));
    check("stall_commit_valid", 64'(bus.commit_valid), 64'(0));
    rdy_in = 1'b1;
    idle();
    bus.label1 = 4'd1;
    #1;
    check("stall_no_wb", 64'(bus.ready1), 64'(0));
    base = n_commits;
    drive_cdb(4'd1, 32'h66, 1'b0, 32'd0);
    step();
    idle();
    wait_commits(base + 1, 5);

    // Reset with four entries in flight
    for (int i = 0; i < 4; i++) issue_checked(K_REG, 5'(i + 12));
    drive_cdb(4'd2, 32'h22, 1'b0, 32'd0);
    step();
    rst_in = 1'b1;
    drive_issue(K_REG, 5'd15, 32'h500);
    drive_cdb(4'd3, 32'h99, 1'b0, 32'd0);
    step();
    rst_in = 1'b0;
    idle();
    check("mr_newTag", 64'(bus.newTag), 64'(1));
    check("mr_isFull", 64'(bus.isFull), 64'(0));
    bus.label1 = 4'd2;
    #1;
    check("mr_freed_ready", 64'(bus.ready1), 64'(0));
    check("mr_freed_res", 64'(bus.res1), 64'(0));
    for (int i = 0; i < 4; i++) begin
      step();
      check("mr_no_commit", 64'(bus.commit_valid), 64'(0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
